// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer and its digit cells.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-BCD load codes (10..15) saturate to the largest legal digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade that counts down 9..0 with wrap and a borrow to the next decade.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       en,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign zero   = (q_q == 4'd0);
  assign borrow = en & zero;

endmodule

// File: rtl/bcd_countdown.sv
// Loadable 3-decade BCD countdown timer with expiry pulse and optional auto-reload.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] d_ones,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_hundreds,
  input  logic       start,
  input  logic       en,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       busy,
  output logic       done
);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [11:0] reload_q, reload_d;

  logic [11:0] load_val;
  logic        tick, expire, reload_now;
  logic        dig_load;
  logic [11:0] dig_val;
  logic        o_zero, t_zero, h_zero;
  logic        o_borrow, t_borrow, h_borrow_unused;

  assign load_val   = {clamp_digit(d_hundreds), clamp_digit(d_tens), clamp_digit(d_ones)};
  // Load outranks any tick in the same cycle, so ticks are masked by load.
  assign tick       = (state_q == ST_RUN) && en && !load;
  assign expire     = tick && h_zero && t_zero && (ones == 4'd1);
  assign reload_now = (AUTO_RELOAD != 0) && expire;
  assign dig_load   = load || reload_now;
  assign dig_val    = load ? load_val : reload_q;

  bcd_down_digit u_ones (
    .clk(clk), .rstn(rstn), .load(dig_load), .d(dig_val[3:0]), .en(tick),
    .q(ones), .zero(o_zero), .borrow(o_borrow)
  );

  bcd_down_digit u_tens (
    .clk(clk), .rstn(rstn), .load(dig_load), .d(dig_val[7:4]), .en(o_borrow),
    .q(tens), .zero(t_zero), .borrow(t_borrow)
  );

  bcd_down_digit u_hundreds (
    .clk(clk), .rstn(rstn), .load(dig_load), .d(dig_val[11:8]), .en(t_borrow),
    .q(hundreds), .zero(h_zero), .borrow(h_borrow_unused)
  );

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    done_d   = expire;
    if (load) begin
      state_d  = ST_IDLE;
      reload_d = load_val;
    end else begin
      case (state_q)
        ST_IDLE: if (start && !(o_zero && t_zero && h_zero)) state_d = ST_RUN;
        ST_RUN:  if (expire && (AUTO_RELOAD == 0)) state_d = ST_ZERO;
        ST_ZERO: state_d = ST_ZERO;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      reload_q <= 12'h000;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      reload_q <= reload_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: one instance per AUTO_RELOAD setting, shared stimulus.
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load, start, en;
  logic [3:0] d_ones, d_tens, d_hundreds;

  logic [3:0] ones, tens, hundreds;
  logic       busy, done;
  logic [3:0] rl_ones, rl_tens, rl_hundreds;
  logic       rl_busy, rl_done;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_cnt  = 0;
  int rl_done_cnt = 0;

  always #5 clk = ~clk;

  bcd_countdown #(.AUTO_RELOAD(0)) u_dut (
    .clk(clk), .rstn(rstn), .load(load), .d_ones(d_ones), .d_tens(d_tens),
    .d_hundreds(d_hundreds), .start(start), .en(en),
    .ones(ones), .tens(tens), .hundreds(hundreds), .busy(busy), .done(done)
  );

  bcd_countdown #(.AUTO_RELOAD(1)) u_rl (
    .clk(clk), .rstn(rstn), .load(load), .d_ones(d_ones), .d_tens(d_tens),
    .d_hundreds(d_hundreds), .start(start), .en(en),
    .ones(rl_ones), .tens(rl_tens), .hundreds(rl_hundreds), .busy(rl_busy), .done(rl_done)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [11:0] cnt();
    return {hundreds, tens, ones};
  endfunction

  function automatic logic [11:0] rl_cnt();
    return {rl_hundreds, rl_tens, rl_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (done)    done_cnt++;
    if (rl_done) rl_done_cnt++;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; d_hundreds = h; d_tens = t; d_ones = o;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
    d_ones = 4'd0; d_tens = 4'd0; d_hundreds = 4'd0;
    repeat (2) step();
    check("reset_count", cnt(), 12'h000);
    check("reset_busy", {11'd0, busy}, 12'd0);
    check("reset_done", {11'd0, done}, 12'd0);
    rstn = 1'b1;
    step();

    // 1: reset mid-run
    done_cnt = 0;
    do_load(4'd0, 4'd5, 4'd0);
    do_start();
    check("t1_busy_run", {11'd0, busy}, 12'd1);
    en = 1'b1;
    repeat (10) step();
    en = 1'b0;
    check("t1_count_040", cnt(), 12'h040);
    rstn = 1'b0;
    #1;
    check("t1_async_count", cnt(), 12'h000);
    check("t1_async_busy", {11'd0, busy}, 12'd0);
    step();
    rstn = 1'b1;
    step();
    check("t1_no_done", 12'(done_cnt), 12'd0);
    check("t1_idle_after", {11'd0, busy}, 12'd0);

    // 2: full countdown 102 -> 000
    done_cnt = 0;
    do_load(4'd1, 4'd0, 4'd2);
    check("t2_loaded", cnt(), 12'h102);
    do_start();
    en = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      step();
      check($sformatf("t2_cnt_%0d", k), cnt(), to_bcd(102 - k));
      check($sformatf("t2_done_%0d", k), {11'd0, done}, (k == 102) ? 12'd1 : 12'd0);
      check($sformatf("t2_busy_%0d", k), {11'd0, busy}, (k == 102) ? 12'd0 : 12'd1);
    end
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_zero_hold", cnt(), 12'h000);
      check("t2_zero_busy", {11'd0, busy}, 12'd0);
    end
    start = 1'b0; en = 1'b0;
    check("t2_done_once", 12'(done_cnt), 12'd1);

    // 3: en gating, then start from 000
    do_load(4'd0, 4'd1, 4'd0);
    do_start();
    begin
      int exp_v;
      exp_v = 10;
      for (int i = 0; i < 8; i++) begin
        en = (i % 2 == 0);
        if (en) exp_v--;
        step();
        check($sformatf("t3_gate_%0d", i), cnt(), to_bcd(exp_v));
      end
      en = 1'b0;
    end
    done_cnt = 0;
    do_load(4'd0, 4'd0, 4'd0);
    do_start();
    en = 1'b1;
    step(); step();
    en = 1'b0;
    check("t3_zero_start_busy", {11'd0, busy}, 12'd0);
    check("t3_zero_start_cnt", cnt(), 12'h000);
    check("t3_zero_start_done", 12'(done_cnt), 12'd0);

    // 4: clamp and priority
    do_load(4'd12, 4'd4, 4'd15);
    check("t4_clamp", cnt(), 12'h949);
    do_start();
    en = 1'b1;
    step();
    check("t4_pre_tick", cnt(), 12'h948);
    load = 1'b1; start = 1'b1; d_hundreds = 4'd3; d_tens = 4'd0; d_ones = 4'd0;
    step();
    load = 1'b0; start = 1'b0;
    check("t4_prio_cnt", cnt(), 12'h300);
    check("t4_prio_busy", {11'd0, busy}, 12'd0);
    step();
    en = 1'b0;
    check("t4_idle_hold", cnt(), 12'h300);

    // 5: auto-reload instance
    rl_done_cnt = 0;
    do_load(4'd0, 4'd0, 4'd3);
    do_start();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t5_cnt_%0d", k), rl_cnt(), to_bcd(3 - (k % 3)));
      check($sformatf("t5_done_%0d", k), {11'd0, rl_done}, (k % 3 == 0) ? 12'd1 : 12'd0);
      check($sformatf("t5_busy_%0d", k), {11'd0, rl_busy}, 12'd1);
    end
    en = 1'b0;
    check("t5_done_cnt", 12'(rl_done_cnt), 12'd2);

    // 6: load during run
    do_load(4'd2, 4'd0, 4'd0);
    do_start();
    en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    check("t6_195", cnt(), 12'h195);
    done_cnt = 0;
    en = 1'b1;
    do_load(4'd0, 4'd2, 4'd0);
    en = 1'b0;
    check("t6_reload_cnt", cnt(), 12'h020);
    check("t6_busy", {11'd0, busy}, 12'd0);
    step();
    check("t6_hold", cnt(), 12'h020);
    check("t6_no_done", 12'(done_cnt), 12'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Loadable 3-decade BCD down counter (countdown timer); the decrementing counterpart of the existing multi-decade BCD up counter.
- Counts from a loaded value 000..999 toward 000 on each enabled cycle, with a borrow chain between decades.
- Pulses done on expiry and can optionally auto-reload for periodic timing.
- Drives the same ones/tens/hundreds digit bus as the up counter, so both can feed the same display logic.

Parameters:
- AUTO_RELOAD, 0, 1 = on expiry the count reloads the stored load value instead of stopping at 000.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- load  input  1  capture d_* into the count and the reload register
- d_ones  input  4  BCD load value, ones digit
- d_tens  input  4  BCD load value, tens digit
- d_hundreds  input  4  BCD load value, hundreds digit
- start  input  1  begin counting from the current value
- en  input  1  count tick; decrement by 1 when running
- ones  output  4  current ones digit
- tens  output  4  current tens digit
- hundreds  output  4  current hundreds digit
- busy  output  1  high while in RUN
- done  output  1  one-cycle registered expiry pulse

Behaviour:
- Reset (rstn=0, asynchronous): ones=tens=hundreds=0, reload register=000, state=IDLE, busy=0, done=0. Reset mid-RUN aborts immediately with no done pulse.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Load clamping: any d_* digit >9 is clamped to 9. The clamped value is written to both the count and the reload register.
- Priority per cycle: rstn > load > start > en.
- load: accepted in any state. Next cycle the state is IDLE, done=0 and busy=0. A start or en in the same cycle as load is ignored.
- FSM states: IDLE, RUN, ZERO.
- IDLE:
  - start=1 with count≠000 → RUN next cycle.
  - start=1 with count=000 → ignored, stays IDLE.
  - en ignored.
- RUN (busy=1):
  - Each cycle with en=1 the count decrements by one in BCD.
  - Ones 0→9 with borrow into tens; tens 0→9 with borrow into hundreds.
  - Borrow out of a digit = en & (lower digits all 0).
  - en=0: count holds. start is ignored in RUN.
- Expiry, en=1 while count=001:
  - AUTO_RELOAD=0: count→000, done=1 on that same edge, state→ZERO.
  - AUTO_RELOAD=1: count→reload value (000 is never displayed), done=1, state stays RUN. Period = reload value en-ticks.
- ZERO: count holds 000; en and start ignored; only load (or reset) leaves ZERO.
- done: high exactly one cycle per expiry, registered and aligned with the count update; never asserted outside an expiry.
- Latency: a count change is visible on the clock edge after the en sample; zero combinational input-to-output paths.
- No wrap-around from 000 to 999 under any condition.

Decomposition:
- Shared package bcd_pkg:
  - state enum (IDLE, RUN, ZERO)
  - constant BCD_MAX = 4'd9
  - a digit-clamp function
- Sub-module bcd_down_digit:
  - ports clk, rstn, load, d (4), en, q (4), zero, borrow
  - borrow = en & (q==0)
  - instantiated three times, with borrow chained into the next decade's en
  - the expiry/reload logic stays in the top level

Test Plan:
1. Reset mid-run: load 050, start, 10 en ticks, then pulse rstn → outputs 000, busy=0, done never asserted.
2. Full countdown with borrows: load 102, start, en held high → sequence 102,101,100,099,…,001,000. done=1 exactly on the 102nd tick edge, then ZERO with busy=0. Further en/start → holds 000.
3. Gating and zero start: load 010, start, en toggled every other cycle → count changes only on en=1 cycles. Separately, load 000 then start → stays IDLE, busy=0, no done.
4. Clamp and priority: load hundreds=12, tens=4, ones=15 → count 949. Assert load+start+en in one cycle with new value 300 → count 300, state IDLE, no decrement.
5. AUTO_RELOAD=1: load 003, start, en high → 002,001,003,002,001,003; done pulses on every third tick; busy stays 1; 000 never appears.
6. Load during RUN: load 200, start, 5 ticks (195), then load 020 → count 020, IDLE, busy=0, no done pulse.
